bf16_div_seq: RTL and testbench

// Iterative bfloat16 divider q = a / b: the inverse of the bf16 multiply feeding the fused adder.

---
 rtl/bf16_div_seq.sv | 197 +++++++++++++++++++
 tb/tb_bf16_div_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_div_seq.sv
// bf16_div_seq: iterative restoring bfloat16 divider with valid/ready on both sides.
// Define BF16_DIV_ROUND_EN for round-to-nearest-even; otherwise the quotient truncates.
module bf16_div_seq #(
    parameter int BITS_PER_CYCLE = 1,
    parameter int EXP_BIAS       = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q,
    output logic [3:0]  flags
);

`ifdef BF16_DIV_ROUND_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif
    localparam int ITERS = 10 / BITS_PER_CYCLE;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_q;
    logic [3:0]  r_flags;
    logic [3:0]  r_cnt;
    logic [8:0]  r_rem;
    logic [9:0]  r_quo;

    logic [8:0]  w_rem_nx;
    logic [9:0]  w_quo_nx;
    logic [9:0]  w_trial;

    logic        w_sign;
    logic [7:0]  w_ea;
    logic [7:0]  w_eb;
    logic [6:0]  w_fa;
    logic [6:0]  w_fb;
    logic [7:0]  w_sig_a;
    logic [7:0]  w_sig_b;
    logic        w_nan_a;
    logic        w_nan_b;
    logic        w_inf_a;
    logic        w_inf_b;
    logic        w_zero_a;
    logic        w_zero_b;

    logic signed [9:0] w_exp;
    logic signed [9:0] w_exp_r;
    logic [6:0]  w_frac;
    logic [7:0]  w_frac_r;
    logic        w_guard;
    logic        w_sticky;
    logic        w_inc;
    logic [15:0] w_q;
    logic [3:0]  w_flags;

    assign w_sign   = r_a[15] ^ r_b[15];
    assign w_ea     = r_a[14:7];
    assign w_eb     = r_b[14:7];
    assign w_fa     = r_a[6:0];
    assign w_fb     = r_b[6:0];
    assign w_sig_a  = {1'b1, w_fa};
    assign w_sig_b  = {1'b1, w_fb};
    assign w_nan_a  = (w_ea == 8'hFF) && (w_fa != 7'd0);
    assign w_nan_b  = (w_eb == 8'hFF) && (w_fb != 7'd0);
    assign w_inf_a  = (w_ea == 8'hFF) && (w_fa == 7'd0);
    assign w_inf_b  = (w_eb == 8'hFF) && (w_fb == 7'd0);
    assign w_zero_a = (w_ea == 8'h00);
    assign w_zero_b = (w_eb == 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nx = S_DIV;
            S_DIV:   if (r_cnt == 4'(ITERS)) w_state_nx = S_NORM;
            S_NORM:  w_state_nx = S_DONE;
            S_DONE:  if (out_ready) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    assign q     = r_q;
    assign flags = r_flags;

    // DIV count 0 unpacks the latched operands; counts 1..ITERS iterate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_flags <= '0;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_cnt <= '0;
                    end
                end
                S_DIV: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd0) begin
                        r_rem <= {1'b0, w_sig_a};
                        r_quo <= '0;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                    end
                end
                S_NORM: begin
                    r_q     <= w_q;
                    r_flags <= w_flags;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rem_nx = r_rem;
        w_quo_nx = r_quo;
        w_trial  = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_trial  = {1'b0, w_rem_nx} - {2'b00, w_sig_b};
            if (!w_trial[9]) w_rem_nx = w_trial[8:0];
            w_quo_nx = {w_quo_nx[8:0], ~w_trial[9]};
            w_rem_nx = {w_rem_nx[7:0], 1'b0};
        end
    end

    always_comb begin
        w_exp = $signed({2'b00, w_ea} - {2'b00, w_eb} + 10'(EXP_BIAS));
        if (r_quo[9]) begin
            w_frac   = r_quo[8:2];
            w_guard  = r_quo[1];
            w_sticky = r_quo[0] | (r_rem != 9'd0);
        end else begin
            w_frac   = r_quo[7:1];
            w_guard  = r_quo[0];
            w_sticky = (r_rem != 9'd0);
            w_exp    = w_exp - 10'sd1;
        end
        w_inc    = RNE & w_guard & (w_sticky | w_frac[0]);
        w_frac_r = {1'b0, w_frac} + {7'd0, w_inc};
        w_exp_r  = w_frac_r[7] ? w_exp + 10'sd1 : w_exp;
    end

    // Specials take priority over the iterated quotient
    always_comb begin
        w_q     = '0;
        w_flags = '0;
        if (w_nan_a | w_nan_b | (w_zero_a & w_zero_b) | (w_inf_a & w_inf_b)) begin
            w_q     = 16'h7FC0;
            w_flags = 4'b1000;
        end else if (w_inf_a) begin
            w_q = {w_sign, 8'hFF, 7'd0};
        end else if (w_zero_b) begin
            w_q     = {w_sign, 8'hFF, 7'd0};
            w_flags = 4'b0100;
        end else if (w_zero_a | w_inf_b) begin
            w_q = {w_sign, 15'd0};
        end else if (w_exp_r >= 10'sd255) begin
            w_q     = {w_sign, 8'hFF, 7'd0};
            w_flags = 4'b0010;
        end else if (w_exp_r <= 10'sd0) begin
            w_q     = {w_sign, 15'd0};
            w_flags = 4'b0001;
        end else begin
            w_q = {w_sign, w_exp_r[7:0], w_frac_r[6:0]};
        end
    end

endmodule

// File: tb/tb_bf16_div_seq.sv
// tb_bf16_div_seq: directed vectors for bf16_div_seq against an arithmetic model.
// Build with BF16_DIV_ROUND_EN to check the round-to-nearest-even variant.
module tb_bf16_div_seq;

    localparam int BPC = 1;
    localparam int LAT = 10 / BPC + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] q;
    logic [3:0]  flags;

    int total = 0;
    int bad = 0;

    logic        armed = 1'b0;
    logic [15:0] exp_q = '0;
    logic [3:0]  exp_f = '0;

    bf16_div_seq #(.BITS_PER_CYCLE(BPC), .EXP_BIAS(127)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .q(q),
        .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Quotient from exact integer division of the significands
    function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y);
        int ea, eb, fa, fb, num, qv, r, e, fr, g, st;
        logic s;
        bit nx, ny, ix, iy, zx, zy;
        s  = x[15] ^ y[15];
        ea = int'(x[14:7]);
        eb = int'(y[14:7]);
        fa = int'(x[6:0]);
        fb = int'(y[6:0]);
        nx = (ea == 255) && (fa != 0);
        ny = (eb == 255) && (fb != 0);
        ix = (ea == 255) && (fa == 0);
        iy = (eb == 255) && (fb == 0);
        zx = (ea == 0);
        zy = (eb == 0);
        if (nx || ny || (zx && zy) || (ix && iy)) return {4'b1000, 16'h7FC0};
        if (ix) return {4'b0000, s, 8'hFF, 7'd0};
        if (zy) return {4'b0100, s, 8'hFF, 7'd0};
        if (zx || iy) return {4'b0000, s, 15'd0};
        num = (128 + fa) * 512;
        qv  = num / (128 + fb);
        r   = num % (128 + fb);
        e   = ea - eb + 127;
        if (qv >= 512) begin
            fr = (qv / 4) % 128;
            g  = (qv / 2) % 2;
            st = ((qv % 2) != 0 || r != 0) ? 1 : 0;
        end else begin
            fr = (qv / 2) % 128;
            g  = qv % 2;
            st = (r != 0) ? 1 : 0;
            e  = e - 1;
        end
`ifdef BF16_DIV_ROUND_EN
        if (g == 1 && (st == 1 || (fr % 2) == 1)) fr = fr + 1;
        if (fr == 128) begin
            fr = 0;
            e  = e + 1;
        end
`endif
        if (e >= 255) return {4'b0010, s, 8'hFF, 7'd0};
        if (e <= 0) return {4'b0001, s, 15'd0};
        return {4'b0000, s, 8'(e), 7'(fr)};
    endfunction

    always @(negedge clk) begin
        if (armed && rst_n && out_valid) begin
            chk("q", {16'd0, q}, {16'd0, exp_q});
            chk("flags", {28'd0, flags}, {28'd0, exp_f});
        end
    end

    task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] lq, input logic [3:0] lf,
                          input bit lit, input int hold);
        logic [19:0] m;
        int n;
        m = model(x, y);
        if (lit) begin
            chk({tag, " model"}, {12'd0, m}, {12'd0, lf, lq});
            exp_q = lq;
            exp_f = lf;
        end else begin
            exp_q = m[15:0];
            exp_f = m[19:16];
        end
        armed = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " idle"}, {31'd0, in_ready}, 32'd1);
        out_ready = (hold == 0);
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'hDEAD;
        b = 16'hBEEF;
        chk({tag, " busy"}, {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, n, LAT);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = 16'h4000;
            b = 16'h4000;
            @(posedge clk); #1;
            chk({tag, " held valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, " held ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, " release ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, " release valid"}, {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        armed = 1'b0;
    endtask

    localparam logic [31:0] VEC [24] = '{
        32'h3FC0_3F80, 32'h4049_402E, 32'hC2F6_4120, 32'h3F80_3F81,
        32'h3F81_3F80, 32'h3F7F_3F80, 32'h7F7F_3F80, 32'h7FC1_3F80,
        32'h3F80_FFC0, 32'h7F80_7F80, 32'hFF80_4000, 32'h4000_7F80,
        32'h0001_3F80, 32'h3F80_0005, 32'h0005_0003, 32'h4120_40A0,
        32'h3DCC_3F4C, 32'h5000_2000, 32'h2000_5000, 32'h3F80_3FFF,
        32'h3FFF_3F80, 32'hBEAA_C0A0, 32'h0200_7E80, 32'h7E00_0180
    };

    initial begin
        #1;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset q", {16'd0, q}, 32'd0);
        chk("reset flags", {28'd0, flags}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("1/1", 16'h3F80, 16'h3F80, 16'h3F80, 4'b0000, 1'b1, 0);
        run_op("6/2", 16'h40C0, 16'h4000, 16'h4040, 4'b0000, 1'b1, 0);
`ifdef BF16_DIV_ROUND_EN
        run_op("1/3", 16'h3F80, 16'h4040, 16'h3EAB, 4'b0000, 1'b1, 0);
`else
        run_op("1/3", 16'h3F80, 16'h4040, 16'h3EAA, 4'b0000, 1'b1, 0);
`endif
        run_op("1/0", 16'h3F80, 16'h0000, 16'h7F80, 4'b0100, 1'b1, 0);
        run_op("0/0", 16'h0000, 16'h0000, 16'h7FC0, 4'b1000, 1'b1, 0);
        run_op("ovf", 16'h7F00, 16'h3F00, 16'h7F80, 4'b0010, 1'b1, 0);
        run_op("unf", 16'h0080, 16'h7F00, 16'h0000, 4'b0001, 1'b1, 0);
        run_op("-1/0", 16'hBF80, 16'h0000, 16'hFF80, 4'b0100, 1'b1, 0);
        run_op("min norm", 16'h0100, 16'h4000, 16'h0080, 4'b0000, 1'b1, 0);
        run_op("below min", 16'h0080, 16'h4000, 16'h0000, 4'b0001, 1'b1, 0);
        run_op("inf/0", 16'h7F80, 16'h0000, 16'h7F80, 4'b0000, 1'b1, 0);
        run_op("-0/2", 16'h8000, 16'h4000, 16'h8000, 4'b0000, 1'b1, 0);
        run_op("max", 16'h7F7F, 16'h3F80, 16'h7F7F, 4'b0000, 1'b1, 0);

        run_op("backpressure", 16'h40C0, 16'h4000, 16'h4040, 4'b0000, 1'b1, 5);

        foreach (VEC[i]) begin
            run_op($sformatf("vec%0d", i), VEC[i][31:16], VEC[i][15:0], 16'h0, 4'h0, 1'b0, 0);
        end

        a = 16'h3F80;
        b = 16'h4040;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort q", {16'd0, q}, 32'd0);
        chk("abort flags", {28'd0, flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after abort", 16'h4000, 16'h3F80, 16'h4000, 4'b0000, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
